// File: rtl/pipe_ctrl.sv
// Hazard controller for the pc_reg -> if_id -> id_ex register chain: jumps, load-use stalls, mul/div waits.
// Optional perf counters (stall_cnt_o, flush_cnt_o) are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MD_TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        load_use_i,
  input  logic        md_start_i,
  input  logic        md_done_i,
  output logic        jump_en_o,
  output logic [31:0] jump_addr_o,
  output logic        hold_pc_o,
  output logic        hold_if_id_o,
  output logic        hold_id_ex_o,
  output logic        flush_if_id_o,
  output logic        flush_id_ex_o,
  output logic        md_timeout_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  typedef enum logic [1:0] {RUN, WAIT_MD, FLUSH} state_e;

  localparam logic [2:0]  FLUSH_LOAD = 3'(FLUSH_CYCLES);
  localparam logic [31:0] MD_LAST    = 32'(MD_TIMEOUT - 1);
  localparam bit          TIMEOUT_EN = (MD_TIMEOUT != 0);
  localparam bit          FLUSH_EN   = (FLUSH_CYCLES != 0);

  state_e      state_q, state_d;
  logic [2:0]  fl_left_q, fl_left_d;
  logic [31:0] md_cnt_q, md_cnt_d;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
    state_d       = state_q;
    fl_left_d     = fl_left_q;
    md_cnt_d      = md_cnt_q;
    jump_en_o     = 1'b0;
    jump_addr_o   = 32'h0;
    hold_pc_o     = 1'b0;
    hold_if_id_o  = 1'b0;
    hold_id_ex_o  = 1'b0;
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;
    md_timeout_o  = 1'b0;

    // Outputs stay quiet while rst is high, whatever the inputs do.
    if (!rst) begin
      unique case (state_q)
        RUN: begin
          if (jump_en_i) begin
            jump_en_o     = 1'b1;
            jump_addr_o   = jump_addr_i;
            flush_if_id_o = 1'b1;
            flush_id_ex_o = 1'b1;
            if (FLUSH_EN) begin
              state_d   = FLUSH;
              fl_left_d = FLUSH_LOAD;
            end
          end else if (md_start_i) begin
            hold_pc_o    = 1'b1;
            hold_if_id_o = 1'b1;
            hold_id_ex_o = 1'b1;
            md_cnt_d     = 32'h0;
            if (!md_done_i) state_d = WAIT_MD;
          end else if (load_use_i) begin
            hold_pc_o     = 1'b1;
            hold_if_id_o  = 1'b1;
            flush_id_ex_o = 1'b1;
          end
        end

        WAIT_MD: begin
          md_cnt_d = md_cnt_q + 32'd1;
          if (md_done_i) begin
            state_d = RUN;
          end else if (TIMEOUT_EN && (md_cnt_q == MD_LAST)) begin
            md_timeout_o = 1'b1;
            state_d      = RUN;
          end else begin
            hold_pc_o    = 1'b1;
            hold_if_id_o = 1'b1;
            hold_id_ex_o = 1'b1;
          end
        end

        FLUSH: begin
          flush_if_id_o = 1'b1;
          if (jump_en_i) begin
            jump_en_o     = 1'b1;
            jump_addr_o   = jump_addr_i;
            flush_id_ex_o = 1'b1;
            fl_left_d     = FLUSH_LOAD;
          end else begin
            fl_left_d = fl_left_q - 3'd1;
            if (fl_left_q == 3'd1) state_d = RUN;
          end
        end

        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q   <= RUN;
      fl_left_q <= 3'd0;
      md_cnt_q  <= 32'h0;
    end else begin
      state_q   <= state_d;
      fl_left_q <= fl_left_d;
      md_cnt_q  <= md_cnt_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters: they stick at all-ones instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hold_pc_o && (stall_cnt_q != 32'hFFFF_FFFF))     stall_cnt_d = stall_cnt_q + 32'd1;
    if (flush_if_id_o && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'h0;
      flush_cnt_q <= 32'h0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  // No performance counters in this build.
`endif

  // A register is never told to hold and flush at once; flush always takes precedence.
  a_if_id_excl: assert property (@(posedge clk) !(hold_if_id_o && flush_if_id_o));
  a_id_ex_excl: assert property (@(posedge clk) !(hold_id_ex_o && flush_id_ex_o));
  a_addr_quiet: assert property (@(posedge clk) jump_en_o || (jump_addr_o == 32'h0));

endmodule
